float_to_int: RTL and testbench

- Sequential converter that consumes the IEEE-754 single-precision `vres` produced by `float_div` (or any float unit) and returns a signed 32-bit integer.
- Conversion truncates toward zero.
- Uses a serial one-bit-per-cycle shifter instead of a barrel shifter, trading latency for area.
- Sits directly downstream of the float datapath; uses a valid/ready handshake on both sides.

---
 rtl/float_to_int.sv | 153 +++++++++++++++
 tb/tb_float_to_int.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/float_to_int.sv
// Converts an IEEE-754 single-precision operand to a signed 32-bit integer, truncating toward zero.
// The magnitude is aligned serially, one bit position per cycle.
module float_to_int #(
   parameter logic [31:0] NAN_VAL = 32'h7FFF_FFFF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        v,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [31:0] ires,
   output logic               out_ovf,
   output logic               out_nan,
   output logic               out_inexact
);

   typedef enum logic [1:0] {IDLE, SHIFT, SIGN, DONE} state_t;

   state_t             state_q, state_d;
   logic [31:0]        mag_q, mag_d;
   logic [4:0]         cnt_q, cnt_d;
   logic               left_q, left_d;
   logic               sign_q, sign_d;
   logic               sticky_q, sticky_d;
   logic signed [31:0] ires_q, ires_d;
   logic               ovf_q, ovf_d;
   logic               nan_q, nan_d;
   logic               inex_q, inex_d;

   logic               v_sign;
   logic [7:0]         v_exp;
   logic [22:0]        v_frac;

   assign v_sign = v[31];
   assign v_exp  = v[30:23];
   assign v_frac = v[22:0];

   function automatic logic signed [31:0] sat_by_sign(input logic s);
      return s ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
   endfunction

   // Magnitude is below 2^31 here, so the negation cannot overflow.
   function automatic logic signed [31:0] apply_sign(input logic s, input logic [31:0] mag);
      return s ? -$signed(mag) : $signed(mag);
   endfunction

   always_comb begin
      state_d  = state_q;
      mag_d    = mag_q;
      cnt_d    = cnt_q;
      left_d   = left_q;
      sign_d   = sign_q;
      sticky_d = sticky_q;
      ires_d   = ires_q;
      ovf_d    = ovf_q;
      nan_d    = nan_q;
      inex_d   = inex_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d   = v_sign;
               sticky_d = 1'b0;
               ovf_d    = 1'b0;
               nan_d    = 1'b0;
               inex_d   = 1'b0;
               state_d  = DONE;
               if (v_exp == 8'hFF && v_frac != 23'd0) begin
                  ires_d = $signed(NAN_VAL);
                  nan_d  = 1'b1;
                  ovf_d  = 1'b1;
               end else if (v_exp == 8'hFF) begin
                  ires_d = sat_by_sign(v_sign);
                  ovf_d  = 1'b1;
               end else if (v == 32'hCF00_0000) begin
                  ires_d = 32'sh8000_0000;
               end else if (v_exp >= 8'd158) begin
                  ires_d = sat_by_sign(v_sign);
                  ovf_d  = 1'b1;
               end else if (v_exp < 8'd127) begin
                  ires_d = 32'sd0;
                  inex_d = (v_exp != 8'd0) || (v_frac != 23'd0);
               end else begin
                  // Binary point sits 23 bits up; exponent 150 needs no alignment.
                  mag_d = {8'b0, 1'b1, v_frac};
                  if (v_exp > 8'd150) begin
                     left_d = 1'b1;
                     cnt_d  = 5'(v_exp - 8'd150);
                  end else begin
                     left_d = 1'b0;
                     cnt_d  = 5'(8'd150 - v_exp);
                  end
                  state_d = (v_exp == 8'd150) ? SIGN : SHIFT;
               end
            end
         end
         SHIFT: begin
            if (left_q) begin
               mag_d = mag_q << 1;
            end else begin
               mag_d    = mag_q >> 1;
               sticky_d = sticky_q | mag_q[0];
            end
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) state_d = SIGN;
         end
         SIGN: begin
            ires_d  = apply_sign(sign_q, mag_q);
            inex_d  = sticky_q;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         mag_q    <= '0;
         cnt_q    <= '0;
         left_q   <= 1'b0;
         sign_q   <= 1'b0;
         sticky_q <= 1'b0;
         ires_q   <= '0;
         ovf_q    <= 1'b0;
         nan_q    <= 1'b0;
         inex_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mag_q    <= mag_d;
         cnt_q    <= cnt_d;
         left_q   <= left_d;
         sign_q   <= sign_d;
         sticky_q <= sticky_d;
         ires_q   <= ires_d;
         ovf_q    <= ovf_d;
         nan_q    <= nan_d;
         inex_q   <= inex_d;
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign ires        = ires_q;
   assign out_ovf     = ovf_q;
   assign out_nan     = nan_q;
   assign out_inexact = inex_q;

endmodule

// File: tb/tb_float_to_int.sv
// Bench for float_to_int: directed and random operands compared with an arithmetic
// reference model, including latency, backpressure and asynchronous reset behaviour.
module tb_float_to_int;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [31:0]        v;
   logic               out_valid;
   logic               out_ready;
   logic signed [31:0] ires;
   logic               out_ovf;
   logic               out_nan;
   logic               out_inexact;

   int n_cmp = 0;
   int n_err = 0;

   float_to_int #(.NAN_VAL(32'h7FFF_FFFF)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .v           (v),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .ires        (ires),
      .out_ovf     (out_ovf),
      .out_nan     (out_nan),
      .out_inexact (out_inexact)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Value = 1.frac * 2^(exp-127), truncated toward zero; specials by classification.
   function automatic void ref_model(input logic [31:0] x, output logic [31:0] r,
                                     output logic ovf, output logic nan,
                                     output logic inex, output int lat);
      logic   s;
      int     ex, e;
      longint m, mag, dv;
      s    = x[31];
      ex   = int'(x[30:23]);
      e    = ex - 127;
      m    = longint'({1'b1, x[22:0]});
      ovf  = 1'b0;
      nan  = 1'b0;
      inex = 1'b0;
      lat  = 1;
      if (ex == 255 && x[22:0] != 0) begin
         r = 32'h7FFF_FFFF; nan = 1'b1; ovf = 1'b1;
      end else if (ex == 255) begin
         r = s ? 32'h8000_0000 : 32'h7FFF_FFFF; ovf = 1'b1;
      end else if (x == 32'hCF00_0000) begin
         r = 32'h8000_0000;
      end else if (e >= 31) begin
         r = s ? 32'h8000_0000 : 32'h7FFF_FFFF; ovf = 1'b1;
      end else if (e < 0) begin
         r = 32'h0;
         inex = (x[30:0] != 0);
      end else begin
         if (e >= 23) begin
            mag = m * (longint'(1) << (e - 23));
            lat = (e - 23) + 2;
         end else begin
            dv   = longint'(1) << (23 - e);
            mag  = m / dv;
            inex = (m % dv) != 0;
            lat  = (23 - e) + 2;
         end
         r = s ? 32'(-mag) : 32'(mag);
      end
   endfunction

   task automatic convert(input logic [31:0] val, input int hold);
      logic [31:0] er;
      logic        eo, en, ei;
      int          el, lat;
      ref_model(val, er, eo, en, ei, el);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      v         = val;
      out_ready = (hold == 0);
      @(negedge clk);
      in_valid = 1'b0;
      v        = $urandom;
      lat      = 1;
      while (!out_valid && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'(el));
      chk("ires", ires, er);
      chk("ovf", 32'(out_ovf), 32'(eo));
      chk("nan", 32'(out_nan), 32'(en));
      chk("inexact", 32'(out_inexact), 32'(ei));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         v        = $urandom;
         @(negedge clk);
         chk("hold_ires", ires, er);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk("hold_valid", 32'(out_valid), 32'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("ready_after", 32'(in_ready), 32'd1);
      chk("valid_after", 32'(out_valid), 32'd0);
   endtask

   logic [31:0] directed [11] = '{
      32'h3F39999A, 32'h40E80000, 32'h42F6CCCD, 32'hC2F6CCCD, 32'h4B800000,
      32'h4B000000, 32'h4F000000, 32'hCF000000, 32'hFF800000, 32'h7FC00000,
      32'h80000000
   };

   initial begin
      int n_seen;
      logic [7:0] ex;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      v         = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_ires", ires, 32'd0);
      chk("rst_flags", {29'd0, out_ovf, out_nan, out_inexact}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      foreach (directed[i]) convert(directed[i], 0);

      convert(32'h42F6CCCD, 10);
      convert(32'h40E80000, 0);
      convert(32'hC2F6CCCD, 0);

      // Abort a conversion while it is still shifting.
      in_valid = 1'b1;
      v        = 32'h40E80000;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_ires", ires, 32'd0);
      #1 rst = 1'b0;
      n_seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid) n_seen++;
      end
      chk("no_output_after_rst", 32'(n_seen), 32'd0);

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 9))
            0:       ex = 8'hFF;
            1:       ex = 8'h00;
            default: ex = 8'($urandom_range(118, 160));
         endcase
         convert({1'($urandom_range(0, 1)), ex, 23'($urandom)}, int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, expected completion");
      $fatal(1);
   end

endmodule
